// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide (16*WORDS-bit) add/subtract built from a single
// 16-bit slice adder. It processes one slice per clock, least significant
// slice first. The carry between slices is held in a register.
// Results and flags are published only on the final slice. Until then the
// partial sums build up in a shadow register, so the outputs stay stable.

module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative
);

  localparam int W     = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // RUN   | one slice per cycle, index counts 0..WORDS-1
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             c_q, c_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             done_q, done_d;

  logic [15:0]      a_sl, b_sl, sum_sl;
  logic             carry_flag, over_sl;
  logic             last_slice;

  // Shared 16-bit slice adder. B is already inverted for subtract, and the
  // initial carry supplies the +1 of the two's complement.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[16*i +: 16];
        b_sl = b_q[16*i +: 16];
      end
    end
    {carry_flag, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + 17'(c_q);
    over_sl    = (a_sl[15] == b_sl[15]) && (sum_sl[15] != a_sl[15]);
    last_slice = (idx_q == IDX_W'(WORDS - 1));
  end

  // Sequencer next-state: latch operands on start, then one slice per cycle
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    shadow_d   = shadow_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          c_d     = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) shadow_d[16*i +: 16] = sum_sl;
        end
        c_d   = carry_flag;
        idx_d = idx_q + IDX_W'(1);
        if (last_slice) begin
          result_d   = shadow_d;
          carry_d    = carry_flag;
          overflow_d = over_sl;
          zero_d     = (shadow_d == '0);
          negative_d = shadow_d[W-1];
          done_d     = 1'b1;
          idx_d      = '0;
          state_d    = S_IDLE;
        end
      end
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      shadow_q   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      shadow_q   <= shadow_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequencer that performs 16*WORDS-bit add and subtract by time-multiplexing one instance of the team's existing 16-bit `addition` block.
- Each cycle it feeds one 16-bit slice to the adder, least significant slice first. The carry is registered between slices.
- Sits between the CPU execute stage and the shared 16-bit adder, so wide arithmetic needs no wider datapath.
- Exposes a start/busy/done handshake plus NZCV-style flags.

Parameters:
- WORDS, 4, number of 16-bit slices per operation (≥2). Operand width W = 16*WORDS.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low. One clock; rst low clears all state immediately.
- start, input, 1: request. Sampled only when the FSM is in IDLE.
- sub, input, 1: 0 = A+B, 1 = A−B. Sampled with start.
- op_a, input, W: operand A. Sampled with start.
- op_b, input, W: operand B. Sampled with start.
- busy, output, 1: high while slices are being processed.
- done, output, 1: one-cycle pulse when result and flags update.
- result, output, W: sum or difference. Held until the next done.
- carry, output, 1: final carry out of the top slice. For subtract, 1 = no borrow.
- overflow, output, 1: signed overflow of the full-width operation.
- zero, output, 1: result == 0.
- negative, output, 1: result[W-1].

Behaviour:
- Reset (rst low, async): FSM = IDLE; busy, done, carry, overflow, zero, negative = 0; result = 0; index = 0. Reset mid-operation aborts it, with no done pulse and no partial result visible.
- FSM states: IDLE, RUN.
- IDLE, start = 1 at edge E0:
  - Latch op_a.
  - Latch op_b, or ~op_b when sub = 1.
  - Carry register = sub.
  - index = 0; go to RUN; busy = 1.
- RUN, each edge:
  - Adder inputs: A slice[index], B' slice[index], carry register as c_i.
  - Write sum into the result shadow slice[index]; carry register = adder carryFlag; index++.
  - On the edge processing index = WORDS-1:
    - Copy shadow to result.
    - carry = carryFlag; overflow = adder over from that slice.
    - zero and negative computed from the final full-width value.
    - Go to IDLE; busy = 0; done = 1 for exactly one cycle.
- Latency: done is high in the cycle following edge E0+WORDS. Throughput is one operation per WORDS cycles.
- result and flags do not change during RUN. The shadow register holds partial sums, so outputs stay stable from one done to the next.
- start while busy: ignored, with no queuing and no effect on the operation in flight.
- start in the done cycle: FSM is already in IDLE, so the request is accepted (back-to-back operation). done deasserts on the next edge while busy reasserts.
- Operand inputs may change freely after the start edge. Only the latched copies are used.
- Arithmetic is modulo 2^W. No saturation.
- The lower slices' over outputs are ignored.

Test Plan:
- WORDS = 4, add 0x0000_0000_0000_FFFF + 0x1 → result 0x0000_0000_0001_0000, C = 0, V = 0, Z = 0, N = 0. done exactly 4 cycles after start, busy high for 4 cycles.
- Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → result 0, C = 1, Z = 1, V = 0. Checks carry ripple across all slices.
- Sub 0x5 − 0x7 → result 0xFFFF_FFFF_FFFF_FFFE, C = 0 (borrow), N = 1, V = 0. Then sub 0x7 − 0x5 → 0x2, C = 1.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 → 0x8000_0000_0000_0000, V = 1, N = 1. Sub 0x8000_0000_0000_0000 − 0x1 → 0x7FFF_FFFF_FFFF_FFFF, V = 1.
- Handshake checks:
  - Pulse start with different operands during RUN → ignored; the first result is unchanged.
  - Assert start in the done cycle → second operation accepted; done reappears 4 cycles later.
  - Previous result holds stable throughout.
- Handshake and reset checks:
  - Assert rst low asynchronously (mid-cycle) at index 2 → all outputs 0 immediately, no done pulse.
  - After release, a new add 0x1 + 0x1 → 0x2 with normal latency.
